// File: rtl/irq_pending_if.sv
// Request/mask/acknowledge bundle between a request source/consumer and irq_pending_ctrl.
interface irq_pending_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic [N-1:0]         req;
  logic                 mask_we;
  logic [N-1:0]         mask_in;
  logic                 ack;
  logic [N-1:0]         pend_vec;
  logic                 irq;
  logic [$clog2(N)-1:0] irq_id;
  logic [CNT_W-1:0]     lost_cnt;

  // Drives requests, mask updates and acknowledges; observes the controller.
  modport master (
    output req, mask_we, mask_in, ack,
    input  pend_vec, irq, irq_id, lost_cnt
  );

  // The controller itself.
  modport slave (
    input  req, mask_we, mask_in, ack,
    output pend_vec, irq, irq_id, lost_cnt
  );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Captures rising edges on raw request lines as pending bits, masks them for the
// downstream 4-to-2 priority encoder, and serves the highest pending line through
// a two-state irq/ack handshake. Edges that hit an already-pending line are counted.
module irq_pending_ctrl #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  irq_pending_if.slave bus
);

  localparam int ID_W = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      req_q;
  logic [N-1:0]      pending_q, pending_d;
  logic [N-1:0]      mask_q, mask_d;
  logic [CNT_W-1:0]  lost_cnt_q, lost_cnt_d;
  logic [ID_W-1:0]   irq_id_q, irq_id_d;

  logic [N-1:0]      rise;
  logic [N-1:0]      clr_vec;
  logic [N-1:0]      pend_vec;
  logic [ID_W-1:0]   top_id;
  logic              lost_hit;

  assign rise     = bus.req & ~req_q;
  assign pend_vec = pending_q & ~mask_q;

  // Highest set bit of the visible pending vector (bit N-1 wins, as in the encoder).
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    top_id = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_vec[i]) top_id = ID_W'(i);
    end
  end

  // Pending/mask/lost-counter next state; a new edge beats a same-cycle clear.
  always_comb begin
    clr_vec = '0;
    if (state_q == SERVE && bus.ack) clr_vec[irq_id_q] = 1'b1;

    pending_d = (pending_q & ~clr_vec) | rise;
    mask_d    = bus.mask_we ? bus.mask_in : mask_q;

    // Collisions on several lines in one cycle still count once.
    lost_hit   = |(rise & pending_q & ~clr_vec);
    lost_cnt_d = lost_cnt_q;
    if (lost_hit && lost_cnt_q != {CNT_W{1'b1}}) lost_cnt_d = lost_cnt_q + 1'b1;
  end

  // Handshake next state; irq_id is captured on grant and frozen while serving.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      IDLE: begin
        if (pend_vec != '0) begin
          state_d  = SERVE;
          irq_id_d = top_id;
        end
      end
      SERVE: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      lost_cnt_q <= '0;
      irq_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= bus.req;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      lost_cnt_q <= lost_cnt_d;
      irq_id_q   <= irq_id_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    bus.irq      = (state_q == SERVE);
    bus.irq_id   = irq_id_q;
    bus.pend_vec = pend_vec;
    bus.lost_cnt = lost_cnt_q;
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: edge capture, priority service, mask,
// lost-request counting and reset behaviour, with hand-computed expectations.
module tb_irq_pending_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  irq_pending_if #(.N(4), .CNT_W(8)) ifc ();

  irq_pending_ctrl #(.N(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    ifc.req     = 4'b0000;
    ifc.mask_we = 1'b0;
    ifc.mask_in = 4'b0000;
    ifc.ack     = 1'b0;

    // 1: reset and idle
    step(); step();
    rst = 1'b0;
    repeat (5) step();
    check("idle_pend", ifc.pend_vec, 4'b0000);
    check("idle_irq",  ifc.irq,      1'b0);
    check("idle_lost", ifc.lost_cnt, 8'd0);

    // 2: single request, one-cycle grant latency, ack clears
    ifc.req = 4'b0001; step(); ifc.req = 4'b0000;
    check("t2_pend_set", ifc.pend_vec, 4'b0001);
    check("t2_irq_lat",  ifc.irq,      1'b0);
    step();
    check("t2_irq",      ifc.irq,      1'b1);
    check("t2_id",       ifc.irq_id,   2'd0);
    step();
    check("t2_irq_hold", ifc.irq,      1'b1);
    ifc.ack = 1'b1; step(); ifc.ack = 1'b0;
    check("t2_ack_irq",  ifc.irq,      1'b0);
    check("t2_ack_pend", ifc.pend_vec, 4'b0000);
    ifc.ack = 1'b1; step(); ifc.ack = 1'b0;
    check("t2_idle_ack_irq",  ifc.irq,      1'b0);
    check("t2_idle_ack_pend", ifc.pend_vec, 4'b0000);

    // 3: two lines, priority order, frozen id under higher arrival
    ifc.req = 4'b1010; step(); ifc.req = 4'b0000;
    check("t3_pend",  ifc.pend_vec, 4'b1010);
    step();
    check("t3_irq_a", ifc.irq,      1'b1);
    check("t3_id_a",  ifc.irq_id,   2'd3);
    ifc.ack = 1'b1; step(); ifc.ack = 1'b0;
    check("t3_gap",      ifc.irq,      1'b0);
    check("t3_pend_mid", ifc.pend_vec, 4'b0010);
    step();
    check("t3_irq_b", ifc.irq,      1'b1);
    check("t3_id_b",  ifc.irq_id,   2'd1);
    ifc.req = 4'b1000; step(); ifc.req = 4'b0000;
    check("t3_frozen_id",  ifc.irq_id,   2'd1);
    check("t3_frozen_irq", ifc.irq,      1'b1);
    check("t3_frozen_pnd", ifc.pend_vec, 4'b1010);
    ifc.ack = 1'b1; step(); ifc.ack = 1'b0;
    check("t3_ack_b_pend", ifc.pend_vec, 4'b1000);
    step();
    check("t3_id_c", ifc.irq_id, 2'd3);
    ifc.ack = 1'b1; step(); ifc.ack = 1'b0;
    check("t3_done_irq",  ifc.irq,      1'b0);
    check("t3_done_pend", ifc.pend_vec, 4'b0000);

    // 4: masked line latches but stays hidden until unmasked
    ifc.mask_we = 1'b1; ifc.mask_in = 4'b1000; step(); ifc.mask_we = 1'b0;
    ifc.req = 4'b1000; step(); ifc.req = 4'b0000;
    check("t4_masked_pend", ifc.pend_vec, 4'b0000);
    step();
    check("t4_masked_irq",  ifc.irq,      1'b0);
    ifc.mask_we = 1'b1; ifc.mask_in = 4'b0000; step(); ifc.mask_we = 1'b0;
    check("t4_unmask_pend", ifc.pend_vec, 4'b1000);
    check("t4_unmask_irq0", ifc.irq,      1'b0);
    step();
    check("t4_unmask_irq",  ifc.irq,      1'b1);
    check("t4_unmask_id",   ifc.irq_id,   2'd3);
    ifc.ack = 1'b1; step(); ifc.ack = 1'b0;
    check("t4_done_pend",   ifc.pend_vec, 4'b0000);

    // 5: lost requests on a masked pending line
    ifc.mask_we = 1'b1; ifc.mask_in = 4'b0100; step(); ifc.mask_we = 1'b0;
    ifc.req = 4'b0100; step(); ifc.req = 4'b0000; step();
    check("t5_lost0", ifc.lost_cnt, 8'd0);
    ifc.req = 4'b0100; step(); ifc.req = 4'b0000; step();
    ifc.req = 4'b0100; step(); ifc.req = 4'b0000;
    check("t5_lost2", ifc.lost_cnt, 8'd2);
    check("t5_pend",  ifc.pend_vec, 4'b0000);
    check("t5_irq",   ifc.irq,      1'b0);

    // 5b: new edge on the line being acknowledged keeps it pending
    ifc.req = 4'b0010; step(); ifc.req = 4'b0000;
    check("t5_p1", ifc.pend_vec, 4'b0010);
    step();
    check("t5_id1", ifc.irq_id, 2'd1);
    ifc.req = 4'b0010; ifc.ack = 1'b1; step(); ifc.req = 4'b0000; ifc.ack = 1'b0;
    check("t5_setwins_pend", ifc.pend_vec, 4'b0010);
    check("t5_setwins_irq",  ifc.irq,      1'b0);
    check("t5_setwins_lost", ifc.lost_cnt, 8'd2);
    step();
    check("t5_reserve_irq", ifc.irq,    1'b1);
    check("t5_reserve_id",  ifc.irq_id, 2'd1);
    ifc.ack = 1'b1; step(); ifc.ack = 1'b0;
    check("t5_reserve_done", ifc.pend_vec, 4'b0000);

    // 5c: two simultaneous collisions count once, then saturation
    ifc.mask_we = 1'b1; ifc.mask_in = 4'b1100; step(); ifc.mask_we = 1'b0;
    ifc.req = 4'b1000; step(); ifc.req = 4'b0000; step();
    ifc.req = 4'b1100; step(); ifc.req = 4'b0000;
    check("t5_multi_lost", ifc.lost_cnt, 8'd3);
    for (int i = 0; i < 260; i++) begin
      ifc.req = 4'b0100; step(); ifc.req = 4'b0000; step();
    end
    check("t5_sat_lost", ifc.lost_cnt, 8'd255);

    // 6: request held through reset release, then reset while serving
    ifc.req = 4'b0100; rst = 1'b1; step(); step();
    rst = 1'b0; step();
    check("t6_held_pend", ifc.pend_vec, 4'b0100);
    check("t6_held_lost", ifc.lost_cnt, 8'd0);
    step();
    check("t6_irq",    ifc.irq,    1'b1);
    check("t6_id",     ifc.irq_id, 2'd2);
    rst = 1'b1; step(); rst = 1'b0; ifc.req = 4'b0000;
    check("t6_rst_irq",  ifc.irq,      1'b0);
    check("t6_rst_pend", ifc.pend_vec, 4'b0000);
    check("t6_rst_lost", ifc.lost_cnt, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
